// File: rtl/nxt_input_conditioner_pkg.sv
// Shared types and constants for the board-input conditioner.
package nxt_input_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/nxt_input_conditioner_sync_ff_chain.sv
// Multi-flop synchroniser for a bus of asynchronous inputs; each bit is an
// independent chain, so multi-bit values may resolve across different cycles.
module nxt_input_conditioner_sync_ff_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign synced = stage[DEPTH-1];

endmodule

// File: rtl/nxt_input_conditioner.sv
// Synchronises the switch bus and the "nxt" button, debounces the button and
// emits one step pulse per press with the switch word frozen at that pulse.
//
// state     | meaning
// IDLE_LOW  | button accepted as released
// WAIT_HIGH | button seen high, counting stable-high cycles
// HIGH      | button accepted as pressed
// WAIT_LOW  | button seen low, counting stable-low cycles
module nxt_input_conditioner
    import nxt_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             nxt_raw,
    input  logic [WIDTH-1:0] sw_raw,
    output logic             nxt_level,
    output logic             nxt_pulse,
    output logic             nxt_release,
    output logic [WIDTH-1:0] sw_sync,
    output logic [WIDTH-1:0] sw_latched
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]       btn_vec;
    logic             btn_s;
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             pulse_next;
    logic             release_next;
    logic [WIDTH-1:0] latched_next;

    nxt_input_conditioner_sync_ff_chain #(
        .WIDTH (1),
        .DEPTH (SYNC_STAGES)
    ) u_sync_nxt (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (nxt_raw),
        .synced (btn_vec)
    );

    nxt_input_conditioner_sync_ff_chain #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync_sw (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (sw_raw),
        .synced (sw_sync)
    );

    assign btn_s = btn_vec[0];

    // Outputs are registered alongside the state so they align with the
    // transition edge rather than trailing it by a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE_LOW;
            cnt         <= '0;
            nxt_level   <= 1'b0;
            nxt_pulse   <= 1'b0;
            nxt_release <= 1'b0;
            sw_latched  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            nxt_level   <= level_next;
            nxt_pulse   <= pulse_next;
            nxt_release <= release_next;
            sw_latched  <= latched_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE_LOW: begin
                if (btn_s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!btn_s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        level_next   = (state_next == HIGH) || (state_next == WAIT_LOW);
        pulse_next   = (state == WAIT_HIGH) && (state_next == HIGH);
        release_next = (state == WAIT_LOW) && (state_next == IDLE_LOW);
        latched_next = pulse_next ? sw_sync : sw_latched;
    end

endmodule

// File: tb/tb_nxt_input_conditioner.sv
// Cycle-by-cycle vector bench for the button/switch input conditioner.
module tb_nxt_input_conditioner;
    import nxt_input_conditioner_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        raw;
        logic [15:0] sw;
        logic        lvl;
        logic        pul;
        logic        rel;
        logic [15:0] lat;
    } vec_t;

    typedef struct {
        logic        lvl;
        logic        pul;
        logic        rel;
        logic [15:0] sync;
        logic [15:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt_raw = 1'b0;
    logic [15:0] sw_raw = '0;
    logic        nxt_level;
    logic        nxt_pulse;
    logic        nxt_release;
    logic [15:0] sw_sync;
    logic [15:0] sw_latched;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pulse = 0;
    int   n_release = 0;
    int   n_alt_err = 0;
    logic last_pulse = 1'b0;

    always #5 clk = ~clk;

    nxt_input_conditioner #(
        .WIDTH           (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nxt_raw     (nxt_raw),
        .sw_raw      (sw_raw),
        .nxt_level   (nxt_level),
        .nxt_pulse   (nxt_pulse),
        .nxt_release (nxt_release),
        .sw_sync     (sw_sync),
        .sw_latched  (sw_latched)
    );

    task automatic add(input logic r, input logic raw, input logic [15:0] sw,
                       input logic lvl, input logic pul, input logic rel,
                       input logic [15:0] lat, input int n);
        vec_t v;
        v.rst_n = r; v.raw = raw; v.sw = sw;
        v.lvl = lvl; v.pul = pul; v.rel = rel; v.lat = lat;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s vec %0d: got %b want %b", name, idx, act, req);
        end
    endtask

    task automatic check16(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    initial begin
        int          bounce [7] = '{1, 1, 0, 1, 1, 1, 0};
        logic [15:0] sm1 = '0;
        logic [15:0] sm2 = '0;
        logic [15:0] lat;
        logic [15:0] s;
        exp_t        e;
        exp_t        got;

        // 1: reset then clean press, pulse 6 edges after raw is first sampled high
        add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2);
        add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 2);
        add(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 6);
        add(1, 1, 16'h0000, 1, 1, 0, 16'h0000, 1);
        add(1, 1, 16'h0000, 1, 0, 0, 16'h0000, 3);
        add(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 6);
        add(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 1);
        add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 2);
        // 2: bounce never completes a window
        for (int i = 0; i < 7; i++) add(1, bounce[i][0], 16'h0000, 0, 0, 0, 16'h0000, 1);
        add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 6);
        // 3: switch change two cycles before the pulse is what gets latched
        add(1, 0, 16'hA5A5, 0, 0, 0, 16'h0000, 3);
        add(1, 1, 16'hA5A5, 0, 0, 0, 16'h0000, 4);
        add(1, 1, 16'h1234, 0, 0, 0, 16'h0000, 2);
        add(1, 1, 16'h1234, 1, 1, 0, 16'h1234, 1);
        add(1, 1, 16'hFFFF, 1, 0, 0, 16'h1234, 4);
        // 4: release with a one-cycle high glitch restarting the window
        add(1, 0, 16'hFFFF, 1, 0, 0, 16'h1234, 2);
        add(1, 1, 16'hFFFF, 1, 0, 0, 16'h1234, 1);
        add(1, 0, 16'hFFFF, 1, 0, 0, 16'h1234, 6);
        add(1, 0, 16'hFFFF, 0, 0, 1, 16'h1234, 1);
        add(1, 0, 16'hFFFF, 0, 0, 0, 16'h1234, 3);
        // 5: reset at cnt=3 with the button held; fresh press afterwards
        add(1, 1, 16'h0F0F, 0, 0, 0, 16'h1234, 5);
        add(0, 1, 16'h0F0F, 0, 0, 0, 16'h0000, 1);
        add(1, 1, 16'h0F0F, 0, 0, 0, 16'h0000, 6);
        add(1, 1, 16'h0F0F, 1, 1, 0, 16'h0F0F, 1);
        add(1, 1, 16'h0F0F, 1, 0, 0, 16'h0F0F, 2);
        add(1, 0, 16'h0F0F, 1, 0, 0, 16'h0F0F, 6);
        add(1, 0, 16'h0F0F, 0, 0, 1, 16'h0F0F, 1);
        add(1, 0, 16'h0F0F, 0, 0, 0, 16'h0F0F, 1);
        // 6: repeated clean presses, each with its own switch word
        lat = 16'h0F0F;
        for (int p = 0; p < 5; p++) begin
            s = {4{4'(p + 1)}};
            add(1, 1, s, 0, 0, 0, lat, 6);
            lat = s;
            add(1, 1, s, 1, 1, 0, lat, 1);
            add(1, 1, s, 1, 0, 0, lat, 1);
            add(1, 0, s, 1, 0, 0, lat, 6);
            add(1, 0, s, 0, 0, 1, lat, 1);
            add(1, 0, s, 0, 0, 0, lat, 1);
        end

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n   = vecs[i].rst_n;
            nxt_raw = vecs[i].raw;
            sw_raw  = vecs[i].sw;
            if (!vecs[i].rst_n) begin
                sm1 = '0;
                sm2 = '0;
            end else begin
                sm2 = sm1;
                sm1 = vecs[i].sw;
            end
            e.lvl = vecs[i].lvl; e.pul = vecs[i].pul; e.rel = vecs[i].rel;
            e.sync = sm2; e.lat = vecs[i].lat;
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            got = sb.pop_front();
            check1("nxt_level", i, nxt_level, got.lvl);
            check1("nxt_pulse", i, nxt_pulse, got.pul);
            check1("nxt_release", i, nxt_release, got.rel);
            check16("sw_sync", i, sw_sync, got.sync);
            check16("sw_latched", i, sw_latched, got.lat);
            if (nxt_pulse && nxt_release) n_alt_err++;
            if (nxt_pulse) begin
                n_pulse++;
                if (last_pulse) n_alt_err++;
                last_pulse = 1'b1;
            end
            if (nxt_release) begin
                n_release++;
                if (!last_pulse) n_alt_err++;
                last_pulse = 1'b0;
            end
        end

        check_int("pulse_count", n_pulse, 8);
        check_int("release_count", n_release, 8);
        check_int("alternation_errors", n_alt_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nxt_input_conditioner.md
Name: nxt_input_conditioner

Overview:
- Board-input front end for the 32-bit ALU bring-up harness.
- Sits directly upstream of the operand/func sequencer, between the raw board pins (16 slide switches, "nxt" push-button) and the sequencer inputs.
- Synchronises all inputs and debounces the button. Emits exactly one clean single-cycle step pulse per physical press.
- Hands the sequencer a switch word frozen at the instant of that pulse, so the sequencer never samples mid-toggle switches or bounce edges.

Parameters:
- WIDTH, 16: switch bus width.
- SYNC_STAGES, 2: flip-flop depth of each synchroniser; legal range is 2 or more.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change. This is 10 ms at 100 MHz. Legal value is 1 or more.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- nxt_raw, input, 1: asynchronous, bouncing push-button pin.
- sw_raw, input, WIDTH: asynchronous slide-switch pins.
- nxt_level, output, 1: debounced button level.
- nxt_pulse, output, 1: one-cycle pulse on an accepted press.
- nxt_release, output, 1: one-cycle pulse on an accepted release.
- sw_sync, output, WIDTH: synchronised, not debounced, live switch value.
- sw_latched, output, WIDTH: sw_sync captured in the cycle nxt_pulse asserts.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All synchroniser flops, counter, FSM, and every output go to 0. FSM state is IDLE_LOW.
  - Reset overrides everything, including an in-progress debounce or a pulse due that cycle.
- Synchronisers:
  - Each input bit passes through SYNC_STAGES flops. Define btn_s as the last nxt stage.
  - sw_sync equals the last switch stage, so the raw-to-sw_sync latency is SYNC_STAGES cycles.
- Counter: width is clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
- FSM states and transitions:
  - IDLE_LOW: if btn_s=1, go to WAIT_HIGH with cnt=1.
  - WAIT_HIGH:
    - If btn_s=0, go to IDLE_LOW with cnt=0. This is a bounce: no pulse.
    - Else if cnt=DEBOUNCE_CYCLES, go to HIGH.
    - Else cnt+1.
  - HIGH: if btn_s=0, go to WAIT_LOW with cnt=1.
  - WAIT_LOW:
    - If btn_s=1, go to HIGH with cnt=0. This is a bounce: no release.
    - Else if cnt=DEBOUNCE_CYCLES, go to IDLE_LOW.
    - Else cnt+1.
- Outputs (all registered):
  - nxt_level=1 exactly while the state is HIGH or WAIT_LOW.
  - nxt_pulse=1 for exactly the one cycle after the WAIT_HIGH to HIGH transition edge.
  - nxt_release=1 for exactly the one cycle after the WAIT_LOW to IDLE_LOW transition edge.
  - nxt_pulse and nxt_release are never both 1.
- Latency: with nxt_raw clean high from edge t0, nxt_pulse is high during the cycle after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES. The same latency applies from a clean low to nxt_release.
- sw_latched:
  - Loads sw_sync at the same edge that raises nxt_pulse.
  - Holds otherwise, including across release and across further switch changes.
- Button held through reset deassertion: treated as a fresh press. After a full debounce window a nxt_pulse is emitted.
- Bounce shorter than DEBOUNCE_CYCLES in either direction produces no pulse and no level change. A glitch restarts the window from zero.
- Switch change during debounce: sw_latched takes the sw_sync value at the pulse edge, not the value at press start.

Decomposition:
- Shared package holds:
  - typedef for the 2-bit FSM state enum: IDLE_LOW=0, WAIT_HIGH=1, HIGH=2, WAIT_LOW=3.
  - Default constants DEBOUNCE_CYCLES_DEFAULT=1000000 and SYNC_STAGES_DEFAULT=2.
  - Sim constant DEBOUNCE_CYCLES_SIM=4.
- One sub-module is natural: sync_ff_chain, parameterised by width and depth, instantiated once for nxt (width 1) and once for sw (width WIDTH). It has no reset dependency beyond rst_n.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset then clean press:
   - Stimulus: rst_n=0 for 2 cycles with nxt_raw=0; release reset; at edge t0 drive nxt_raw=1 and hold.
   - Required: nxt_pulse=1 only in the cycle after edge t0+6; nxt_level=1 from then on; all outputs 0 before.
2. Bounce rejection:
   - Stimulus: nxt_raw pattern 1,1,0,1,1,1,0 (one value per cycle), then 0 steady.
   - Required: no nxt_pulse, nxt_level stays 0, FSM returns to IDLE_LOW.
3. Latch timing:
   - Stimulus: sw_raw=16'hA5A5; press; change sw_raw to 16'h1234 two cycles before the expected pulse (visible on sw_sync by the pulse edge).
   - Required: sw_latched=16'h1234 at the pulse. It stays 16'h1234 after sw_raw moves to 16'hFFFF.
4. Release:
   - Stimulus: from HIGH, drive nxt_raw=0 with one 1-cycle high glitch at cycle 2.
   - Required: nxt_release asserted once, 4 clean low cycles after the glitch; nxt_level falls with it; no second nxt_pulse.
5. Reset mid-debounce:
   - Stimulus: assert rst_n=0 while in WAIT_HIGH (cnt=3), with nxt_raw held 1.
   - Required: outputs 0 immediately after the reset edge; after release, exactly one nxt_pulse 6 cycles later.
6. Repeated presses:
   - Stimulus: 5 clean press/release cycles.
   - Required: exactly 5 nxt_pulse and 5 nxt_release pulses, strictly alternating.
